axis_usb_packetizer: RTL



---
 rtl/usb_pkt_pkg.sv | 22 ++
 rtl/axis_out_reg.sv | 29 ++
 rtl/axis_usb_packetizer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/usb_pkt_pkg.sv
// Shared definitions for the USB packet framer and the host-side parser.
// The ST_CKSUM state exists only when USB_PKT_CHECKSUM_EN is defined.
package usb_pkt_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned SEQ_W  = 4;
    localparam int unsigned LEN_W  = 12;

    localparam logic [WORD_W-1:0] SYNC_WORD_DEFAULT = 16'hA5C3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_HDR,
        ST_PAYLOAD,
`ifdef USB_PKT_CHECKSUM_EN
        ST_CKSUM,
`endif
        ST_DONE
    } state_t;

endpackage

// File: rtl/axis_out_reg.sv
// Single-stage valid/ready output register; a new word is captured
// in the same cycle the held word transfers.
module axis_out_reg #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    output logic         can_load,
    output logic         out_val,
    input  logic         out_rdy,
    output logic [W-1:0] out_data
);

    assign can_load = ~out_val | out_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_val  <= 1'b0;
            out_data <= '0;
        end else if (can_load) begin
            out_val <= load;
            if (load)
                out_data <= load_data;
        end
    end

endmodule

// File: rtl/axis_usb_packetizer.sv
// Frames a 16-bit sample stream into sync/header/payload packets for the FT245 TX path.
// Define USB_PKT_CHECKSUM_EN to append a two's-complement checksum word.
module axis_usb_packetizer
    import usb_pkt_pkg::*;
#(
    parameter int unsigned       PKT_LEN   = 256,
    parameter logic [WORD_W-1:0] SYNC_WORD = SYNC_WORD_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              in_val,
    output logic              in_rdy,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_val,
    input  logic              out_rdy,
    output logic [WORD_W-1:0] out_data,
    output logic              busy,
    output logic [31:0]       pkt_cnt
);

    state_t            state;
    state_t            state_nxt;
    logic [SEQ_W-1:0]  seq;
    logic [LEN_W-1:0]  word_cnt;
    logic              can_load;
    logic              load;
    logic [WORD_W-1:0] load_data;
    logic              accept;
    logic              last_word;
    logic              pkt_end;

    assign accept    = in_val & in_rdy;
    assign last_word = (word_cnt == LEN_W'(PKT_LEN - 1));
    // The last word is still in the output register while in DONE, so
    // the packet is complete exactly when that register can reload.
    assign pkt_end   = (state == ST_DONE) & can_load;
    assign busy      = (state != ST_IDLE);

`ifdef USB_PKT_CHECKSUM_EN
    logic [WORD_W-1:0] checksum;

    always_ff @(posedge clk) begin
        if (rst || pkt_end)
            checksum <= '0;
        else if (accept)
            checksum <= checksum + in_data;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seq      <= '0;
            word_cnt <= '0;
            pkt_cnt  <= '0;
        end else begin
            if (state == ST_HDR && can_load) begin
                seq      <= seq + 1'b1;
                word_cnt <= '0;
            end else if (accept) begin
                word_cnt <= word_cnt + 1'b1;
            end
            if (pkt_end)
                pkt_cnt <= pkt_cnt + 32'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_data = '0;
        in_rdy    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable && in_val)
                    state_nxt = ST_SYNC;
            end
            ST_SYNC: begin
                if (can_load) begin
                    load      = 1'b1;
                    load_data = SYNC_WORD;
                    state_nxt = ST_HDR;
                end
            end
            ST_HDR: begin
                if (can_load) begin
                    load      = 1'b1;
                    load_data = {seq, LEN_W'(PKT_LEN)};
                    state_nxt = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                in_rdy = can_load;
                if (in_val && can_load) begin
                    load      = 1'b1;
                    load_data = in_data;
                    if (last_word) begin
`ifdef USB_PKT_CHECKSUM_EN
                        state_nxt = ST_CKSUM;
`else
                        state_nxt = ST_DONE;
`endif
                    end
                end
            end
`ifdef USB_PKT_CHECKSUM_EN
            ST_CKSUM: begin
                if (can_load) begin
                    load      = 1'b1;
                    load_data = ~checksum + 16'd1;
                    state_nxt = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                if (can_load)
                    state_nxt = (enable && in_val) ? ST_SYNC : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    axis_out_reg #(
        .W(WORD_W)
    ) u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_data(load_data),
        .can_load (can_load),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_data (out_data)
    );

endmodule
